// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Arbitrates one single-port data memory between the CPU MEM stage and the
//   program loader. Grants are combinational from the live requests and the
//   registered state. The CPU has priority unless the loader holds a burst
//   lock or has been denied STARVE_MAX consecutive cycles. Reads return one
//   cycle after their grant on the port that issued them.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   IDLE     | no read response due this cycle
//   RESP_CPU | memory read data belongs to the CPU port
//   RESP_LD  | memory read data belongs to the loader port
//
// Ports
//   clk, reset                   clock, async active-high reset
//   i_cpu_req/we/addr/wdata      CPU request port
//   o_cpu_gnt, o_cpu_stall       CPU grant / pipeline hold
//   o_cpu_rvalid, o_cpu_rdata    CPU read response
//   i_ld_req/we/addr/wdata/lock  loader request port with burst lock
//   o_ld_gnt                     loader grant
//   o_ld_rvalid, o_ld_rdata      loader read response
//   o_mem_read/write/addr/wdata  memory strobes, address and write data
//   i_mem_rdata                  memory read data (cycle after o_mem_read)
module dmem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic        o_cpu_gnt,
  output logic        o_cpu_stall,
  output logic        o_cpu_rvalid,
  output logic [31:0] o_cpu_rdata,
  input  logic        i_ld_req,
  input  logic        i_ld_we,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_wdata,
  input  logic        i_ld_lock,
  output logic        o_ld_gnt,
  output logic        o_ld_rvalid,
  output logic [31:0] o_ld_rdata,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RESP_CPU, RESP_LD} state_t;

  state_t        r_state;
  logic [SW-1:0] r_starve;
  logic          r_lock;

  logic w_ld_win;
  logic w_cpu_gnt;
  logic w_ld_gnt;

  // Loader wins when alone, when locked, or when starved. The lock also
  // blocks a lone CPU request: the burst owns the memory until it ends.
  // Grants are masked by reset so every output is 0 while reset is high.
  assign w_ld_win  = i_ld_req & (~i_cpu_req | r_lock | (r_starve == STARVE_TOP));
  assign w_ld_gnt  = ~reset & w_ld_win;
  assign w_cpu_gnt = ~reset & i_cpu_req & ~r_lock & ~w_ld_win;

  assign o_cpu_gnt   = w_cpu_gnt;
  assign o_ld_gnt    = w_ld_gnt;
  assign o_cpu_stall = ~reset & i_cpu_req & ~w_cpu_gnt;

  always_comb begin
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_cpu_gnt) begin
      o_mem_read  = ~i_cpu_we;
      o_mem_write = i_cpu_we;
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (w_ld_gnt) begin
      o_mem_read  = ~i_ld_we;
      o_mem_write = i_ld_we;
      o_mem_addr  = i_ld_addr;
      o_mem_wdata = i_ld_wdata;
    end
  end

  // Response routing comes straight from the registered state, which the
  // async reset forces to IDLE, so rvalid/rdata are 0 during reset.
  assign o_cpu_rvalid = (r_state == RESP_CPU);
  assign o_ld_rvalid  = (r_state == RESP_LD);
  assign o_cpu_rdata  = (r_state == RESP_CPU) ? i_mem_rdata : '0;
  assign o_ld_rdata   = (r_state == RESP_LD)  ? i_mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_lock   <= 1'b0;
    end else begin
      if (w_cpu_gnt && !i_cpu_we) begin
        r_state <= RESP_CPU;
      end else if (w_ld_gnt && !i_ld_we) begin
        r_state <= RESP_LD;
      end else begin
        r_state <= IDLE;
      end

      if (!i_ld_req || w_ld_gnt) begin
        r_starve <= '0;
      end else if (r_starve != STARVE_TOP) begin
        r_starve <= r_starve + SW'(1);
      end

      // A locked grant (re)arms the lock; dropping either request or lock ends it.
      if (w_ld_gnt && i_ld_lock) begin
        r_lock <= 1'b1;
      end else if (!i_ld_req || !i_ld_lock) begin
        r_lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, ld_req, ld_we, ld_lock;
  logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata, mem_rdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ld_gnt, ld_rvalid;
  logic        mem_read, mem_write;
  logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_cpu_req    (cpu_req),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_gnt    (cpu_gnt),
    .o_cpu_stall  (cpu_stall),
    .o_cpu_rvalid (cpu_rvalid),
    .o_cpu_rdata  (cpu_rdata),
    .i_ld_req     (ld_req),
    .i_ld_we      (ld_we),
    .i_ld_addr    (ld_addr),
    .i_ld_wdata   (ld_wdata),
    .i_ld_lock    (ld_lock),
    .o_ld_gnt     (ld_gnt),
    .o_ld_rvalid  (ld_rvalid),
    .o_ld_rdata   (ld_rdata),
    .o_mem_read   (mem_read),
    .o_mem_write  (mem_write),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cwd;
    logic        lr, lw, ll;
    logic [31:0] la, lwd, mrd;
    logic        cg, lg, st, mr, mw;
    logic [31:0] ma, mwd;
    logic        crv;
    logic [31:0] crd;
    logic        lrv;
    logic [31:0] lrd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                       input logic [31:0] cwd, input logic lr, input logic lw,
                       input logic ll, input logic [31:0] la, input logic [31:0] lwd,
                       input logic [31:0] mrd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd;
    ld_req = lr; ld_we = lw; ld_lock = ll; ld_addr = la; ld_wdata = lwd;
    mem_rdata = mrd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            cr    cw    ca      cwd           lr    lw    ll    la      lwd    mrd
    //            cg    lg    st    mr    mw    ma      mwd           crv   crd           lrv   lrd
    vecs[0] = '{1'b1, 1'b0, 32'h10, '0,           1'b0, 1'b0, 1'b0, '0,     '0,    '0,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, '0,           1'b0, '0,           1'b0, '0};
    vecs[1] = '{1'b0, 1'b0, '0,     '0,           1'b0, 1'b0, 1'b0, '0,     '0,    32'hDEADBEEF,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0,     '0,           1'b1, 32'hDEADBEEF, 1'b0, '0};
    vecs[2] = '{1'b0, 1'b0, '0,     '0,           1'b1, 1'b0, 1'b0, 32'h20, 32'h5, 32'h11111111,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h5,        1'b0, '0,           1'b0, '0};
    vecs[3] = '{1'b1, 1'b0, 32'h30, '0,           1'b0, 1'b0, 1'b0, '0,     '0,    32'hA5A5A5A5,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30, '0,           1'b0, '0,           1'b1, 32'hA5A5A5A5};
    vecs[4] = '{1'b0, 1'b0, '0,     '0,           1'b1, 1'b0, 1'b0, 32'h40, '0,    32'h12345678,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, '0,           1'b1, 32'h12345678, 1'b0, '0};
    vecs[5] = '{1'b1, 1'b1, 32'h50, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, '0,     '0,    32'h9,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h50, 32'hCAFEF00D, 1'b0, '0,           1'b1, 32'h9};
    vecs[6] = '{1'b0, 1'b0, '0,     '0,           1'b1, 1'b1, 1'b0, 32'h60, 32'h0BADC0DE, 32'h77,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h60, 32'h0BADC0DE, 1'b0, '0,           1'b0, '0};
    vecs[7] = '{1'b0, 1'b0, '0,     '0,           1'b0, 1'b0, 1'b0, '0,     '0,    32'h88,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0,     '0,           1'b0, '0,           1'b0, '0};
    vecs[8] = '{1'b1, 1'b0, 32'h70, 32'h1,        1'b1, 1'b0, 1'b0, 32'h80, 32'h2, '0,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h70, 32'h1,        1'b0, '0,           1'b0, '0};
    vecs[9] = '{1'b0, 1'b0, '0,     '0,           1'b0, 1'b0, 1'b0, '0,     '0,    32'h99,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0,     '0,           1'b1, 32'h99,       1'b0, '0};

    // Reset with live requests: every output must be 0.
    reset = 1'b1;
    drive(1'b1, 1'b0, 32'h10, 32'h3, 1'b1, 1'b0, 1'b1, 32'h20, 32'h4, 32'hFFFFFFFF);
    #2;
    chk("rst_cpu_gnt",   {31'b0, cpu_gnt},   32'h0);
    chk("rst_ld_gnt",    {31'b0, ld_gnt},    32'h0);
    chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst_mem_read",  {31'b0, mem_read},  32'h0);
    chk("rst_mem_addr",  mem_addr,           32'h0);
    chk("rst_mem_wdata", mem_wdata,          32'h0);
    chk("rst_cpu_rdata", cpu_rdata,          32'h0);
    chk("rst_ld_rdata",  ld_rdata,           32'h0);
    @(negedge clk);
    @(negedge clk);
    drive('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    reset = 1'b0;

    // Table: single-cycle grants, muxing and 1-cycle read responses.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cwd, vecs[i].lr,
            vecs[i].lw, vecs[i].ll, vecs[i].la, vecs[i].lwd, vecs[i].mrd);
      @(negedge clk);
      chk($sformatf("v%0d_cpu_gnt", i),    {31'b0, cpu_gnt},    {31'b0, vecs[i].cg});
      chk($sformatf("v%0d_ld_gnt", i),     {31'b0, ld_gnt},     {31'b0, vecs[i].lg});
      chk($sformatf("v%0d_cpu_stall", i),  {31'b0, cpu_stall},  {31'b0, vecs[i].st});
      chk($sformatf("v%0d_mem_read", i),   {31'b0, mem_read},   {31'b0, vecs[i].mr});
      chk($sformatf("v%0d_mem_write", i),  {31'b0, mem_write},  {31'b0, vecs[i].mw});
      chk($sformatf("v%0d_mem_addr", i),   mem_addr,            vecs[i].ma);
      chk($sformatf("v%0d_mem_wdata", i),  mem_wdata,           vecs[i].mwd);
      chk($sformatf("v%0d_cpu_rvalid", i), {31'b0, cpu_rvalid}, {31'b0, vecs[i].crv});
      chk($sformatf("v%0d_cpu_rdata", i),  cpu_rdata,           vecs[i].crd);
      chk($sformatf("v%0d_ld_rvalid", i),  {31'b0, ld_rvalid},  {31'b0, vecs[i].lrv});
      chk($sformatf("v%0d_ld_rdata", i),   ld_rdata,            vecs[i].lrd);
    end

    // Contention for 10 cycles: loader forced in on cycles 4 and 9.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(1'b1, 1'b0, 32'h100 + i, '0, 1'b1, 1'b0, 1'b0, 32'h200 + i, '0, 32'h5000 + i);
      @(negedge clk);
      chk($sformatf("starve%0d_cpu_gnt", i),   {31'b0, cpu_gnt},   {31'b0, !(i == 4 || i == 9)});
      chk($sformatf("starve%0d_ld_gnt", i),    {31'b0, ld_gnt},    {31'b0, (i == 4 || i == 9)});
      chk($sformatf("starve%0d_cpu_stall", i), {31'b0, cpu_stall}, {31'b0, (i == 4 || i == 9)});
      chk($sformatf("starve%0d_ld_rvalid", i), {31'b0, ld_rvalid}, {31'b0, (i == 5)});
      chk($sformatf("starve%0d_cpu_rvalid", i), {31'b0, cpu_rvalid}, {31'b0, (i != 0 && i != 5)});
    end
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);

    // Locked loader write burst against a writing CPU. Cycles 0-3 starve the
    // loader, 4-6 are the burst, 7 drops the lock (CPU still held by lock_r),
    // 8 is the first CPU grant after the burst.
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      drive(1'b1, 1'b1, 32'h300, 32'h33, (i < 7), 1'b1, (i < 7), 32'h400 + i, 32'h44, '0);
      @(negedge clk);
      chk($sformatf("lock%0d_cpu_gnt", i),   {31'b0, cpu_gnt},   {31'b0, (i < 4 || i == 8)});
      chk($sformatf("lock%0d_ld_gnt", i),    {31'b0, ld_gnt},    {31'b0, (i >= 4 && i <= 6)});
      chk($sformatf("lock%0d_cpu_stall", i), {31'b0, cpu_stall}, {31'b0, (i >= 4 && i <= 7)});
      chk($sformatf("lock%0d_mem_write", i), {31'b0, mem_write}, {31'b0, (i != 7)});
      chk($sformatf("lock%0d_mem_read", i),  {31'b0, mem_read},  32'h0);
      chk($sformatf("lock%0d_rvalid", i),    {30'b0, cpu_rvalid, ld_rvalid}, 32'h0);
      if (i >= 4 && i <= 6) chk($sformatf("lock%0d_mem_addr", i), mem_addr, 32'h400 + i);
    end
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);

    // Build up starvation, then reset mid-cycle right after a CPU read grant.
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive(1'b1, 1'b0, 32'h500, '0, 1'b1, 1'b0, 1'b0, 32'h600, '0, 32'h77);
      @(negedge clk);
      chk($sformatf("pre%0d_cpu_gnt", i), {31'b0, cpu_gnt}, 32'h1);
    end
    next_cycle();
    #1;
    chk("midrst_gnt_before", {31'b0, cpu_gnt},    32'h1);
    chk("midrst_rv_before",  {31'b0, cpu_rvalid}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_cpu_gnt",    {31'b0, cpu_gnt},    32'h0);
    chk("midrst_cpu_stall",  {31'b0, cpu_stall},  32'h0);
    chk("midrst_mem_read",   {31'b0, mem_read},   32'h0);
    chk("midrst_mem_addr",   mem_addr,            32'h0);
    chk("midrst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
    chk("midrst_cpu_rdata",  cpu_rdata,           32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      if (k == 0) chk("post_rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
      chk($sformatf("post%0d_ld_gnt", k),  {31'b0, ld_gnt},  {31'b0, (k == 4)});
      chk($sformatf("post%0d_cpu_gnt", k), {31'b0, cpu_gnt}, {31'b0, (k != 4)});
    end
    next_cycle();
    drive('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
